// File: rtl/uart_mmio_ctrl.sv
// UART MMIO controller: an RX FIFO fed by the receiver, a one-byte TX holding
// register for the transmitter, and status/control registers. Reads return
// data one cycle after the request.
module uart_mmio_ctrl #(
  parameter int unsigned RX_DEPTH = 8,
  localparam int unsigned CNT_W   = $clog2(RX_DEPTH) + 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mmio_en,
  input  logic        mmio_we,
  input  logic [1:0]  mmio_addr,
  input  logic [7:0]  mmio_wdata,
  output logic [31:0] mmio_rdata,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready
);

  localparam int unsigned PtrW = (RX_DEPTH > 1) ? $clog2(RX_DEPTH) : 1;

  localparam logic [1:0] AddrStatus = 2'd0;
  localparam logic [1:0] AddrRxData = 2'd1;
  localparam logic [1:0] AddrTxData = 2'd2;
  localparam logic [1:0] AddrCtrl   = 2'd3;

  logic [7:0]       mem_q [RX_DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             overrun_q, overrun_d;
  logic             tx_drop_q, tx_drop_d;
  logic [7:0]       tx_data_q, tx_data_d;
  logic             tx_valid_q, tx_valid_d;
  logic [31:0]      rdata_q, rdata_d;

  logic rd_req, wr_req, full, empty, push_req, push, pop;
  logic flush, clear, tx_wr, tx_hs;

  assign rx_ready   = ~rst;
  assign tx_data    = tx_data_q;
  assign tx_valid   = tx_valid_q;
  assign mmio_rdata = rdata_q;

  // Decode MMIO access and FIFO/TX events for this cycle.
  always_comb begin
    rd_req   = mmio_en & ~mmio_we;
    wr_req   = mmio_en & mmio_we;
    full     = (cnt_q == CNT_W'(RX_DEPTH));
    empty    = (cnt_q == '0);
    flush    = wr_req && (mmio_addr == AddrCtrl) && mmio_wdata[1];
    clear    = wr_req && (mmio_addr == AddrCtrl) && mmio_wdata[0];
    tx_wr    = wr_req && (mmio_addr == AddrTxData);
    tx_hs    = tx_valid_q & tx_ready;
    pop      = rd_req && (mmio_addr == AddrRxData) && !empty;
    push_req = rx_valid & rx_ready;
    // A pop this cycle frees a slot, so a push into a full FIFO still lands.
    push     = push_req && !flush && (!full || pop);
  end

  // Next-state for FIFO pointers, flags, TX holding register and read data.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    cnt_d      = cnt_q;
    tx_data_d  = tx_data_q;
    tx_valid_d = tx_valid_q;
    rdata_d    = '0;

    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      cnt_d = cnt_q + CNT_W'(push) - CNT_W'(pop);
    end

    // Set events take priority over a same-cycle clear.
    overrun_d = (overrun_q & ~clear) | (push_req && !flush && full && !pop);
    tx_drop_d = (tx_drop_q & ~clear) | (tx_wr && tx_valid_q && !tx_hs);

    if (tx_wr && (!tx_valid_q || tx_hs)) begin
      tx_data_d  = mmio_wdata;
      tx_valid_d = 1'b1;
    end else if (tx_hs) begin
      tx_valid_d = 1'b0;
    end

    if (rd_req) begin
      unique case (mmio_addr)
        AddrStatus: begin
          rdata_d[0]              = ~tx_valid_q;
          rdata_d[1]              = ~empty;
          rdata_d[2]              = overrun_q;
          rdata_d[3]              = tx_drop_q;
          rdata_d[8 +: CNT_W]     = cnt_q;
        end
        AddrRxData: if (pop) rdata_d[7:0] = mem_q[rd_ptr_q];
        default:    rdata_d = '0;
      endcase
    end
  end

  // FIFO storage; contents need no reset since count gates every read.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= rx_data;
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      overrun_q  <= 1'b0;
      tx_drop_q  <= 1'b0;
      tx_data_q  <= '0;
      tx_valid_q <= 1'b0;
      rdata_q    <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      cnt_q      <= cnt_d;
      overrun_q  <= overrun_d;
      tx_drop_q  <= tx_drop_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
      rdata_q    <= rdata_d;
    end
  end

endmodule

// File: tb/tb_uart_mmio_ctrl.sv
// Directed bench for uart_mmio_ctrl: inputs driven on falling edges,
// outputs sampled on the following falling edge.
module tb_uart_mmio_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mmio_en = 1'b0;
  logic        mmio_we = 1'b0;
  logic [1:0]  mmio_addr = '0;
  logic [7:0]  mmio_wdata = '0;
  logic [31:0] mmio_rdata;
  logic [7:0]  rx_data = '0;
  logic        rx_valid = 1'b0;
  logic        rx_ready;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b0;

  int n_checks = 0;
  int n_pass   = 0;
  logic [31:0] rd;

  always #5 clk = ~clk;

  uart_mmio_ctrl #(.RX_DEPTH(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .mmio_en    (mmio_en),
    .mmio_we    (mmio_we),
    .mmio_addr  (mmio_addr),
    .mmio_wdata (mmio_wdata),
    .mmio_rdata (mmio_rdata),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  task automatic push(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic mmio_wr(input logic [1:0] a, input logic [7:0] d);
    mmio_en = 1'b1; mmio_we = 1'b1; mmio_addr = a; mmio_wdata = d;
    @(negedge clk);
    mmio_en = 1'b0; mmio_we = 1'b0;
  endtask

  task automatic mmio_rd(input logic [1:0] a, output logic [31:0] d);
    mmio_en = 1'b1; mmio_we = 1'b0; mmio_addr = a;
    @(negedge clk);
    mmio_en = 1'b0;
    d = mmio_rdata;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check("reset tx_valid", {31'b0, tx_valid}, 32'h0);
    check("reset rdata", mmio_rdata, 32'h0);
    rst = 1'b0;
    #1 check("rx_ready", {31'b0, rx_ready}, 32'h1);
    @(negedge clk);
    mmio_rd(2'd0, rd); check("reset status", rd, 32'h0000_0001);

    // Two pushes then two pops.
    push(8'h41); push(8'h42);
    mmio_rd(2'd0, rd); check("status two bytes", rd, 32'h0000_0203);
    mmio_rd(2'd1, rd); check("pop 0x41", rd, 32'h41);
    mmio_rd(2'd1, rd); check("pop 0x42", rd, 32'h42);
    mmio_rd(2'd0, rd); check("status drained", rd, 32'h0000_0001);
    mmio_rd(2'd1, rd); check("pop empty", rd, 32'h0);

    // Overrun: nine pushes into eight slots.
    for (int i = 0; i < 9; i++) push(8'h10 + 8'(i));
    mmio_rd(2'd0, rd); check("status overrun", rd, 32'h0000_0807);
    for (int i = 0; i < 8; i++) begin
      mmio_rd(2'd1, rd); check("pop overrun data", rd, 32'h10 + 32'(i));
    end
    mmio_rd(2'd0, rd); check("status overrun sticky", rd, 32'h0000_0005);
    mmio_wr(2'd3, 8'h01);
    mmio_rd(2'd0, rd); check("status after clear", rd, 32'h0000_0001);

    // Full FIFO with simultaneous push and pop.
    for (int i = 0; i < 8; i++) push(8'h20 + 8'(i));
    rx_data = 8'h55; rx_valid = 1'b1;
    mmio_en = 1'b1; mmio_we = 1'b0; mmio_addr = 2'd1;
    @(negedge clk);
    rx_valid = 1'b0; mmio_en = 1'b0;
    check("pop while full", mmio_rdata, 32'h20);
    mmio_rd(2'd0, rd); check("status full no overrun", rd, 32'h0000_0803);
    for (int i = 1; i < 8; i++) begin
      mmio_rd(2'd1, rd); check("pop after swap", rd, 32'h20 + 32'(i));
    end
    mmio_rd(2'd1, rd); check("pop 0x55 last", rd, 32'h55);
    mmio_rd(2'd0, rd); check("status empty again", rd, 32'h0000_0001);

    // Empty FIFO with simultaneous push and pop: no bypass.
    rx_data = 8'h66; rx_valid = 1'b1;
    mmio_en = 1'b1; mmio_we = 1'b0; mmio_addr = 2'd1;
    @(negedge clk);
    rx_valid = 1'b0; mmio_en = 1'b0;
    check("pop empty with push", mmio_rdata, 32'h0);
    mmio_rd(2'd0, rd); check("status one byte", rd, 32'h0000_0103);
    mmio_rd(2'd1, rd); check("pop 0x66", rd, 32'h66);

    // TX holding register and drop.
    tx_ready = 1'b0;
    mmio_wr(2'd2, 8'hA5);
    check("tx_valid loaded", {31'b0, tx_valid}, 32'h1);
    check("tx_data loaded", {24'b0, tx_data}, 32'hA5);
    mmio_wr(2'd2, 8'h5A);
    check("tx_data held", {24'b0, tx_data}, 32'hA5);
    mmio_rd(2'd0, rd); check("status tx_drop", rd, 32'h0000_0008);
    mmio_rd(2'd2, rd); check("read tx offset", rd, 32'h0);
    tx_ready = 1'b1;
    @(negedge clk);
    tx_ready = 1'b0;
    check("tx_valid after hs", {31'b0, tx_valid}, 32'h0);

    // Write during a handshake is accepted.
    mmio_wr(2'd2, 8'h11);
    tx_ready = 1'b1;
    mmio_wr(2'd2, 8'h3C);
    tx_ready = 1'b0;
    check("tx_valid hs+write", {31'b0, tx_valid}, 32'h1);
    check("tx_data hs+write", {24'b0, tx_data}, 32'h3C);
    mmio_rd(2'd3, rd); check("read ctrl offset", rd, 32'h0);
    mmio_wr(2'd3, 8'h01);
    mmio_rd(2'd0, rd); check("status tx_drop cleared", rd, 32'h0000_0000);

    // Flush.
    push(8'h01); push(8'h02);
    mmio_wr(2'd3, 8'h02);
    mmio_rd(2'd0, rd); check("status after flush", rd, 32'h0000_0000);

    // Reset mid-stream with RX bytes, overrun-free flags and pending TX.
    mmio_wr(2'd3, 8'h01);
    for (int i = 0; i < 3; i++) push(8'h70 + 8'(i));
    mmio_rd(2'd0, rd); check("status three bytes", rd, 32'h0000_0302);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("tx_valid after rst", {31'b0, tx_valid}, 32'h0);
    mmio_rd(2'd0, rd); check("status after rst", rd, 32'h0000_0001);
    mmio_rd(2'd1, rd); check("pop after rst", rd, 32'h0);
    @(negedge clk);
    check("rdata idle", mmio_rdata, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/uart_mmio_ctrl.md
Name: uart_mmio_ctrl

Overview:
Memory-mapped controller that sequences the UART receive and transmit datapaths for the CPU. It buffers received bytes from the UART receiver's ready/valid output in an RX FIFO. It holds one outgoing byte for the UART transmitter. It exposes status, RX data, TX data and control registers on a simple word-offset MMIO port with one-cycle read latency.

Parameters:
RX_DEPTH, 8, RX FIFO entries; power of two, 2..128
CNT_W, $clog2(RX_DEPTH)+1, width of RX occupancy count (derived; do not override)

Ports:
clk  input  1  system clock; all logic on rising edge
rst  input  1  synchronous, active-high reset
mmio_en  input  1  access request this cycle
mmio_we  input  1  1 = write, 0 = read (qualified by mmio_en)
mmio_addr  input  2  word offset: 0 status, 1 rx data, 2 tx data, 3 control
mmio_wdata  input  8  write data (byte)
mmio_rdata  output  32  read data, valid the cycle after the read request
rx_data  input  8  byte from UART receiver
rx_valid  input  1  receiver byte valid
rx_ready  output  1  controller accepts byte; tied high (see Behaviour)
tx_data  output  8  byte to UART transmitter
tx_valid  output  1  holding register full
tx_ready  input  1  transmitter can accept byte

Behaviour:
- Clock and reset: one clock domain, clk; reset is synchronous and active-high (rst).
- Reset values: RX FIFO read/write pointers and count = 0; overrun and tx_drop flags = 0; holding register empty; tx_valid = 0; tx_data = 0; mmio_rdata = 0. rx_ready = 1 outside reset.
- Reset mid-operation discards all buffered RX bytes and any pending TX byte. A transfer already inside the transmitter is not affected.
- RX push: rx_valid & rx_ready.
  - Not full: write rx_data at the write pointer, advance the pointer (wraps modulo RX_DEPTH), count+1.
  - Full and no pop this cycle: byte discarded, overrun flag set (sticky), count unchanged.
- RX pop: MMIO read at offset 1.
  - Non-empty: mmio_rdata next cycle = {24'b0, head byte}; read pointer advances (wraps); count-1.
  - Empty: mmio_rdata = 0, no state change.
- Simultaneous push and pop:
  - Both take effect; count unchanged.
  - When full, the push is accepted because the pop frees a slot; no overrun.
  - When empty, the read returns 0 (no bypass) and the pushed byte is stored; count becomes 1.
- Status read (offset 0), returned next cycle:
  - bit0 = holding register empty
  - bit1 = RX non-empty
  - bit2 = overrun
  - bit3 = tx_drop
  - bits[8+CNT_W-1:8] = RX count
  - all other bits 0
  - Reflects state before any same-cycle update.
- TX write (offset 2):
  - Holding empty: load mmio_wdata[7:0] into tx_data; tx_valid = 1 from the next cycle.
  - Holding full: write dropped, tx_drop flag set (sticky).
  - Write in the same cycle as a tx_valid & tx_ready handshake: accepted; the new byte loads and tx_valid stays 1.
- TX handshake: tx_valid & tx_ready with no same-cycle write clears tx_valid next cycle. tx_data is stable while tx_valid = 1.
- Control write (offset 3):
  - wdata bit0 = 1 clears overrun and tx_drop.
  - wdata bit1 = 1 flushes the RX FIFO (pointers and count to 0).
  - A flag-set event in the same cycle as a clear wins (flag ends set).
  - A push in the same cycle as a flush is discarded.
- Reads of offsets 2/3 return 0. Writes to offsets 0/1 are ignored.
- Cycles with mmio_en = 0 leave mmio_rdata at 0.
- Read latency is exactly 1 cycle; there are no wait states and no back-pressure on the MMIO port.

Test Plan:
- Reset, then read offset 0 -> mmio_rdata = 0x00000001 next cycle; tx_valid = 0.
- Push 0x41, 0x42, then read offset 1 twice -> 0x41 then 0x42; status then = 0x00000001.
- Push 9 bytes 0x10..0x18 with RX_DEPTH = 8 -> status bit2 = 1, count field = 8; reads return 0x10..0x17. Control write 0x01 -> bit2 clears.
- FIFO full with push 0x55 and offset-1 read in the same cycle -> read returns the oldest byte, count stays 8, no overrun, 0x55 is the last byte read out.
- tx_ready = 0; write 0xA5 then 0x5A to offset 2 -> tx_data = 0xA5 held, tx_drop = 1. Raise tx_ready one cycle -> tx_valid drops the next cycle.
- Fill 3 RX bytes, assert rst for one cycle mid-stream -> count = 0, flags = 0, read offset 1 returns 0.
